// File: rtl/logicnet_pkg.sv
// rtl/logicnet_pkg.sv - shared types and helpers for the LogicNet input packer
package logicnet_pkg;

  // Width of one quantized feature code in the packed vector
  localparam int CODE_W = 2;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PRESENT = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  // LSB position of feature slot idx inside the packed vector
  function automatic int slot_lsb(input int idx);
    return idx * CODE_W;
  endfunction

endpackage

// File: rtl/logicnet_quantizer.sv
// rtl/logicnet_quantizer.sv - signed three-threshold 2-bit quantizer
module logicnet_quantizer
  import logicnet_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic signed [IN_W-1:0]   x_i,
  input  logic signed [IN_W-1:0]   t0_i,
  input  logic signed [IN_W-1:0]   t1_i,
  input  logic signed [IN_W-1:0]   t2_i,
  output logic        [CODE_W-1:0] code_o
);

  logic ge0, ge1, ge2;

  // Count how many thresholds the sample reaches; works for any threshold order
  always_comb begin
    ge0    = (x_i >= t0_i);
    ge1    = (x_i >= t1_i);
    ge2    = (x_i >= t2_i);
    code_o = {1'b0, ge0} + {1'b0, ge1} + {1'b0, ge2};
  end

endmodule

// File: rtl/logicnet_input_packer.sv
// rtl/logicnet_input_packer.sv - serial feature quantizer and packer for LogicNet layer 0
module logicnet_input_packer
  import logicnet_pkg::*;
#(
  parameter int NUM_FEATURES = 16,
  parameter int IN_W         = 16,
  parameter int IDX_W        = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic signed [IN_W-1:0]           s_data,
  input  logic                             s_last,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [CODE_W*NUM_FEATURES-1:0]   m_data,
  input  logic                             cfg_we,
  input  logic [IDX_W-1:0]                 cfg_addr,
  input  logic [1:0]                       cfg_sel,
  input  logic signed [IN_W-1:0]           cfg_data,
  output logic                             err_frame
);

  localparam int VEC_W = CODE_W * NUM_FEATURES;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       cnt_q, cnt_d;
  logic [VEC_W-1:0]       vec_q, vec_d;
  logic                   s_ready_q, s_ready_d;
  logic                   m_valid_q, m_valid_d;
  logic                   err_q, err_d;
  logic signed [IN_W-1:0] thr_q [NUM_FEATURES][3];
  logic [CODE_W-1:0]      code;
  logic                   beat, consume, last_slot;

  assign beat      = s_valid & s_ready_q;
  assign consume   = m_valid_q & m_ready;
  assign last_slot = (cnt_q == IDX_W'(NUM_FEATURES - 1));

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_data    = vec_q;
  assign err_frame = err_q;

  // Thresholds of the feature currently being collected
  logicnet_quantizer #(.IN_W(IN_W)) u_quant (
    .x_i    (s_data),
    .t0_i   (thr_q[cnt_q][0]),
    .t1_i   (thr_q[cnt_q][1]),
    .t2_i   (thr_q[cnt_q][2]),
    .code_o (code)
  );

  // Threshold table; a same-cycle write is seen by the following beat only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int f = 0; f < NUM_FEATURES; f++) begin
        for (int t = 0; t < 3; t++) begin
          thr_q[f][t] <= '0;
        end
      end
    end else if (cfg_we && (cfg_sel != 2'd3) && (int'(cfg_addr) < NUM_FEATURES)) begin
      thr_q[cfg_addr][cfg_sel] <= cfg_data;
    end
  end

  // State, counter, vector and registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= COLLECT;
      cnt_q     <= '0;
      vec_q     <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vec_q     <= vec_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      err_q     <= err_d;
    end
  end

  // Next state: frame assembly, length checking, drain of overlong frames
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    err_d   = 1'b0;
    if (consume) vec_d = '0;
    case (state_q)
      COLLECT: begin
        if (beat) begin
          vec_d[slot_lsb(int'(cnt_q)) +: CODE_W] = code;
          if (last_slot) begin
            cnt_d = '0;
            if (s_last) begin
              state_d = PRESENT;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end else if (s_last) begin
            cnt_d   = '0;
            err_d   = 1'b1;
            state_d = PRESENT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PRESENT: begin
        if (consume) state_d = COLLECT;
      end
      DRAIN: begin
        if (beat && s_last) begin
          state_d = (m_valid_q && !m_ready) ? PRESENT : COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Output next values derived from the upcoming state so they can be registered
  always_comb begin
    s_ready_d = (state_d != PRESENT);
    m_valid_d = 1'b0;
    case (state_d)
      PRESENT: m_valid_d = 1'b1;
      DRAIN:   m_valid_d = (state_q == DRAIN) ? (m_valid_q & ~m_ready) : 1'b1;
      default: m_valid_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_logicnet_input_packer.sv
// tb/tb_logicnet_input_packer.sv - directed self-checking bench for logicnet_input_packer
module tb_logicnet_input_packer;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_valid, s_ready, s_last;
  logic signed [15:0] s_data;
  logic               m_valid, m_ready;
  logic [31:0]        m_data;
  logic               cfg_we;
  logic [3:0]         cfg_addr;
  logic [1:0]         cfg_sel;
  logic signed [15:0] cfg_data;
  logic               err_frame;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logicnet_input_packer #(.NUM_FEATURES(16), .IN_W(16), .IDX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .err_frame (err_frame)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic signed [15:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [1:0] sel, input logic signed [15:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_sel  = sel;
    cfg_data = d;
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic consume_vec();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_sel = '0; cfg_data = '0;
    step(); step();
    chk("reset_s_ready", {31'd0, s_ready}, 32'd0);
    chk("reset_m_valid", {31'd0, m_valid}, 32'd0);
    chk("reset_m_data", m_data, 32'd0);
    chk("reset_err", {31'd0, err_frame}, 32'd0);
    rst = 1'b1;
    step();
    chk("post_reset_s_ready", {31'd0, s_ready}, 32'd1);

    for (int f = 0; f < 16; f++) begin
      cfg_write(4'(f), 2'd0, -16'sd10);
      cfg_write(4'(f), 2'd1, 16'sd0);
      cfg_write(4'(f), 2'd2, 16'sd10);
    end

    // Codes 0 (-20) and 2 (5) alternating from slot 0
    for (int i = 0; i < 16; i++) beat((i % 2) ? 16'sd5 : -16'sd20, i == 15);
    chk("a_m_valid", {31'd0, m_valid}, 32'd1);
    chk("a_m_data", m_data, 32'h8888_8888);
    chk("a_err", {31'd0, err_frame}, 32'd0);
    chk("a_s_ready", {31'd0, s_ready}, 32'd0);
    consume_vec();
    chk("a_after_m_valid", {31'd0, m_valid}, 32'd0);
    chk("a_after_s_ready", {31'd0, s_ready}, 32'd1);
    chk("a_after_cleared", m_data, 32'd0);

    // Codes 3 (10) and 1 (-10) with a held downstream
    for (int i = 0; i < 16; i++) beat((i % 2) ? -16'sd10 : 16'sd10, i == 15);
    chk("b_m_data", m_data, 32'h7777_7777);
    s_valid = 1'b1; s_data = 16'sd0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("b_hold_m_valid", {31'd0, m_valid}, 32'd1);
      chk("b_hold_m_data", m_data, 32'h7777_7777);
      chk("b_hold_s_ready", {31'd0, s_ready}, 32'd0);
    end
    s_valid = 1'b0;
    consume_vec();
    chk("b_release_s_ready", {31'd0, s_ready}, 32'd1);
    chk("b_release_m_valid", {31'd0, m_valid}, 32'd0);

    // Short frame
    for (int i = 0; i < 3; i++) beat(16'sd100, i == 2);
    chk("short_m_data", m_data, 32'h0000_003F);
    chk("short_m_valid", {31'd0, m_valid}, 32'd1);
    chk("short_err", {31'd0, err_frame}, 32'd1);
    step();
    chk("short_err_pulse_end", {31'd0, err_frame}, 32'd0);
    chk("short_m_data_held", m_data, 32'h0000_003F);
    consume_vec();

    // Long frame of 18 beats
    for (int i = 0; i < 18; i++) begin
      beat(16'sd100, i == 17);
      if (i == 15) begin
        chk("long_err", {31'd0, err_frame}, 32'd1);
        chk("long_drain_m_valid", {31'd0, m_valid}, 32'd1);
        chk("long_drain_m_data", m_data, 32'hFFFF_FFFF);
        chk("long_drain_s_ready", {31'd0, s_ready}, 32'd1);
      end
      if (i == 16) chk("long_err_pulse_end", {31'd0, err_frame}, 32'd0);
    end
    chk("long_present_m_valid", {31'd0, m_valid}, 32'd1);
    chk("long_present_s_ready", {31'd0, s_ready}, 32'd0);
    chk("long_present_m_data", m_data, 32'hFFFF_FFFF);
    consume_vec();
    for (int i = 0; i < 16; i++) beat((i % 2) ? -16'sd10 : 16'sd10, i == 15);
    chk("after_long_m_data", m_data, 32'h7777_7777);
    chk("after_long_err", {31'd0, err_frame}, 32'd0);
    consume_vec();

    // Threshold rewrites mid-frame: before beat 5, and concurrent with beat 6
    for (int i = 0; i < 16; i++) begin
      if (i == 5) cfg_write(4'd5, 2'd2, 16'sd200);
      if (i == 6) begin
        cfg_we = 1'b1; cfg_addr = 4'd6; cfg_sel = 2'd2; cfg_data = 16'sd200;
      end
      beat((i == 5 || i == 6) ? 16'sd150 : -16'sd20, i == 15);
      cfg_we = 1'b0;
    end
    chk("cfg_mid_frame_m_data", m_data, 32'h0000_3800);
    consume_vec();

    // Reset while presenting
    for (int i = 0; i < 3; i++) beat(16'sd100, i == 2);
    chk("pre_rst_m_valid", {31'd0, m_valid}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_present_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_present_m_data", m_data, 32'd0);
    chk("rst_present_s_ready", {31'd0, s_ready}, 32'd0);
    #2 rst = 1'b1;
    step();
    chk("rst_present_recover", {31'd0, s_ready}, 32'd1);

    // Reset mid-collect
    for (int i = 0; i < 5; i++) beat(16'sd100, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_collect_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_collect_m_data", m_data, 32'd0);
    #2 rst = 1'b1;
    step();

    // Thresholds are back to zero: every non-negative sample codes to 3
    for (int i = 0; i < 16; i++) beat((i % 2) ? 16'sd7 : 16'sd0, i == 15);
    chk("zero_thr_m_data", m_data, 32'hFFFF_FFFF);
    chk("zero_thr_err", {31'd0, err_frame}, 32'd0);
    consume_vec();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
